// File: rtl/tmr_fault_supervisor_if.sv
`default_nettype none
// ============================================================================
//  Module      : tmr_fault_supervisor_if
//  Description : Fault-event channel from the TMR supervisor to the system
//                monitor (valid/ready handshake plus sticky overflow flag).
//  Revision    : 1.0 - initial release
// ============================================================================
interface tmr_fault_supervisor_if;
   logic       evt_valid;
   logic       evt_ready;
   logic [3:0] evt_code;
   logic       evt_ovf;

   modport master (
      output evt_valid,
      output evt_code,
      output evt_ovf,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_code,
      input  evt_ovf,
      output evt_ready
   );
endinterface
`default_nettype wire

// File: rtl/tmr_fault_supervisor.sv
`default_nettype none
// ============================================================================
//  Module      : tmr_fault_supervisor
//  Description : Supervisor for a triplicated counter. Votes the three
//                replicas, gates the count enable, sequences resync after a
//                single-replica fault, retires a repeat offender and reports
//                fault events to the system monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tmr_fault_supervisor #(
   parameter int WIDTH         = 64,
   parameter int CNT_W         = 16,
   parameter int STRIKES       = 3,
   parameter int CLEAN_WIN     = 16,
   parameter int RESYNC_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic                   clear,
   input  logic [WIDTH-1:0]       q_1,
   input  logic [WIDTH-1:0]       q_2,
   input  logic [WIDTH-1:0]       q_3,
   output logic [WIDTH-1:0]       voted_q,
   output logic                   cnt_enable,
   output logic                   resync,
   output logic [2:0]             mask,
   output logic [1:0]             state,
   output logic                   alarm,
   output logic [CNT_W-1:0]       fault_cnt_1,
   output logic [CNT_W-1:0]       fault_cnt_2,
   output logic [CNT_W-1:0]       fault_cnt_3,
   tmr_fault_supervisor_if.master evt
);

   typedef enum logic [1:0] {
      ST_NORMAL   = 2'd0,
      ST_RESYNC   = 2'd1,
      ST_DEGRADED = 2'd2,
      ST_FAIL     = 2'd3
   } state_t;

   // Counters only need to span their own ranges; strikes saturate at STRIKES.
   localparam int c_STRK_W  = $clog2(STRIKES + 1);
   localparam int c_CLEAN_W = (CLEAN_WIN > 1) ? $clog2(CLEAN_WIN) : 1;
   localparam int c_RS_W    = (RESYNC_CYCLES > 1) ? $clog2(RESYNC_CYCLES) : 1;
   localparam logic [c_STRK_W-1:0]  c_STRIKES    = c_STRK_W'(STRIKES);
   localparam logic [c_CLEAN_W-1:0] c_CLEAN_LAST = c_CLEAN_W'(CLEAN_WIN - 1);
   localparam logic [c_RS_W-1:0]    c_RS_LAST    = c_RS_W'(RESYNC_CYCLES - 1);
   localparam logic [CNT_W-1:0]     c_CNT_MAX    = '1;

   state_t                     r_state;
   logic [2:0]                 r_mask;
   logic [2:0][CNT_W-1:0]      r_fault_cnt;
   logic [2:0][c_STRK_W-1:0]   r_strike;
   logic [c_CLEAN_W-1:0]       r_clean;
   logic [c_RS_W-1:0]          r_rs_cnt;
   logic [WIDTH-1:0]           r_last_good;
   logic                       r_evt_valid;
   logic [3:0]                 r_evt_code;
   logic                       r_evt_ovf;

   logic                       w_eq12, w_eq13, w_eq23, w_no_majority;
   logic [WIDTH-1:0]           w_voted;
   logic [2:0]                 w_mis;
   logic [2:0]                 w_at_max;
   logic                       w_one_max;
   logic                       w_deg_eq;
   logic                       w_evt_new;
   logic [3:0]                 w_evt_code;

   // Replica id (1..3) of the lowest set bit, 0 when none is set.
   function automatic logic [1:0] lowest_id(input logic [2:0] v);
      if (v[0])      return 2'd1;
      else if (v[1]) return 2'd2;
      else if (v[2]) return 2'd3;
      return 2'd0;
   endfunction

   assign w_eq12        = (q_1 == q_2);
   assign w_eq13        = (q_1 == q_3);
   assign w_eq23        = (q_2 == q_3);
   assign w_no_majority = ~(w_eq12 | w_eq13 | w_eq23);
   assign w_mis         = {q_3 != w_voted, q_2 != w_voted, q_1 != w_voted};
   assign w_at_max      = {r_strike[2] == c_STRIKES, r_strike[1] == c_STRIKES,
                           r_strike[0] == c_STRIKES};
   assign w_one_max     = (w_at_max != 3'b000) && ((w_at_max & (w_at_max - 3'd1)) == 3'b000);

   // Select the value fed back to the replicas for the current state.
   always_comb begin
      w_voted = r_last_good;
      case (r_state)
         ST_NORMAL, ST_RESYNC: begin
            if (w_eq12 || w_eq13) w_voted = q_1;
            else if (w_eq23)      w_voted = q_2;
            else                  w_voted = (q_1 & q_2) | (q_1 & q_3) | (q_2 & q_3);
         end
         ST_DEGRADED: begin
            if (!r_mask[0])      w_voted = q_1;
            else if (!r_mask[1]) w_voted = q_2;
            else                 w_voted = q_3;
         end
         default: w_voted = r_last_good;
      endcase
   end

   // In DEGRADED only the two surviving replicas are compared.
   always_comb begin
      case (r_mask)
         3'b001:  w_deg_eq = w_eq23;
         3'b010:  w_deg_eq = w_eq13;
         default: w_deg_eq = w_eq12;
      endcase
   end

   // Count gating: any disagreement stalls the replicas for that cycle.
   always_comb begin
      case (r_state)
         ST_NORMAL:   cnt_enable = enable & ~(|w_mis);
         ST_DEGRADED: cnt_enable = enable & w_deg_eq;
         default:     cnt_enable = 1'b0;
      endcase
   end

   // Event raised this cycle by the supervisor state machine.
   always_comb begin
      w_evt_new  = 1'b0;
      w_evt_code = 4'b0000;
      case (r_state)
         ST_NORMAL: begin
            if (w_no_majority) begin
               w_evt_new  = 1'b1;
               w_evt_code = 4'b1100;
            end else if (|w_mis) begin
               w_evt_new  = 1'b1;
               w_evt_code = {2'b01, lowest_id(w_mis)};
            end
         end
         ST_RESYNC: begin
            if (r_rs_cnt == c_RS_LAST && w_one_max) begin
               w_evt_new  = 1'b1;
               w_evt_code = {2'b10, lowest_id(w_at_max)};
            end
         end
         ST_DEGRADED: begin
            if (!w_deg_eq) begin
               w_evt_new  = 1'b1;
               w_evt_code = 4'b1100;
            end
         end
         default: ;
      endcase
   end

   // Supervisor state machine with fault, strike and clean-window bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_NORMAL;
         r_mask      <= '0;
         r_fault_cnt <= '0;
         r_strike    <= '0;
         r_clean     <= '0;
         r_rs_cnt    <= '0;
         r_last_good <= '0;
      end else if (clear) begin
         r_state     <= ST_NORMAL;
         r_mask      <= '0;
         r_fault_cnt <= '0;
         r_strike    <= '0;
         r_clean     <= '0;
         r_rs_cnt    <= '0;
         r_last_good <= '0;
      end else begin
         if (r_state != ST_FAIL) r_last_good <= w_voted;
         case (r_state)
            ST_NORMAL: begin
               if (w_no_majority) begin
                  r_state <= ST_FAIL;
               end else if (|w_mis) begin
                  r_state  <= ST_RESYNC;
                  r_rs_cnt <= '0;
                  r_clean  <= '0;
                  for (int i = 0; i < 3; i++) begin
                     if (w_mis[i]) begin
                        if (r_fault_cnt[i] != c_CNT_MAX)
                           r_fault_cnt[i] <= r_fault_cnt[i] + CNT_W'(1);
                        if (r_strike[i] != c_STRIKES)
                           r_strike[i] <= r_strike[i] + c_STRK_W'(1);
                     end
                  end
               end else if (r_clean == c_CLEAN_LAST) begin
                  r_clean  <= '0;
                  r_strike <= '0;
               end else begin
                  r_clean <= r_clean + c_CLEAN_W'(1);
               end
            end
            ST_RESYNC: begin
               if (r_rs_cnt == c_RS_LAST) begin
                  r_rs_cnt <= '0;
                  if (w_one_max) begin
                     r_state <= ST_DEGRADED;
                     r_mask  <= r_mask | w_at_max;
                     for (int i = 0; i < 3; i++) begin
                        if (w_at_max[i]) r_strike[i] <= '0;
                     end
                  end else if (|w_at_max) begin
                     r_state <= ST_FAIL;
                  end else begin
                     r_state <= ST_NORMAL;
                  end
               end else begin
                  r_rs_cnt <= r_rs_cnt + c_RS_W'(1);
               end
            end
            ST_DEGRADED: begin
               if (!w_deg_eq) r_state <= ST_FAIL;
            end
            default: r_state <= ST_FAIL;
         endcase
      end
   end

   // Single-entry event holding register; a blocked new event sets overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_evt_valid <= 1'b0;
         r_evt_code  <= 4'b0000;
         r_evt_ovf   <= 1'b0;
      end else if (clear) begin
         r_evt_valid <= 1'b0;
         r_evt_code  <= 4'b0000;
         r_evt_ovf   <= 1'b0;
      end else if (w_evt_new) begin
         if (!r_evt_valid || evt.evt_ready) begin
            r_evt_valid <= 1'b1;
            r_evt_code  <= w_evt_code;
         end else begin
            r_evt_ovf <= 1'b1;
         end
      end else if (r_evt_valid && evt.evt_ready) begin
         r_evt_valid <= 1'b0;
      end
   end

   assign voted_q       = w_voted;
   assign state         = r_state;
   assign mask          = r_mask;
   assign resync        = (r_state == ST_RESYNC);
   assign alarm         = (r_state == ST_FAIL);
   assign fault_cnt_1   = r_fault_cnt[0];
   assign fault_cnt_2   = r_fault_cnt[1];
   assign fault_cnt_3   = r_fault_cnt[2];
   assign evt.evt_valid = r_evt_valid;
   assign evt.evt_code  = r_evt_code;
   assign evt.evt_ovf   = r_evt_ovf;

endmodule
`default_nettype wire

// File: tb/tb_tmr_fault_supervisor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tmr_fault_supervisor
//  Description : Directed self-checking bench for tmr_fault_supervisor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tmr_fault_supervisor;
   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        clear;
   logic [63:0] q_1, q_2, q_3;
   logic [63:0] voted_q;
   logic        cnt_enable;
   logic        resync;
   logic [2:0]  mask;
   logic [1:0]  state;
   logic        alarm;
   logic [15:0] fault_cnt_1, fault_cnt_2, fault_cnt_3;

   int n_checks = 0;
   int n_errors = 0;

   tmr_fault_supervisor_if bus ();

   tmr_fault_supervisor #(
      .WIDTH(64), .CNT_W(16), .STRIKES(3), .CLEAN_WIN(16), .RESYNC_CYCLES(2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .clear       (clear),
      .q_1         (q_1),
      .q_2         (q_2),
      .q_3         (q_3),
      .voted_q     (voted_q),
      .cnt_enable  (cnt_enable),
      .resync      (resync),
      .mask        (mask),
      .state       (state),
      .alarm       (alarm),
      .fault_cnt_1 (fault_cnt_1),
      .fault_cnt_2 (fault_cnt_2),
      .fault_cnt_3 (fault_cnt_3),
      .evt         (bus)
   );

   always #5 clk = ~clk;

   // Move to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_q(input int idx, input logic [63:0] v);
      case (idx)
         1:       q_1 = v;
         2:       q_2 = v;
         default: q_3 = v;
      endcase
   endtask

   // One-cycle glitch on replica idx; returns in the first RESYNC cycle.
   task automatic inject(input int idx, input logic [63:0] bad);
      tick();
      set_q(idx, bad);
      #1;
      tick();
      set_q(idx, 64'd5);
      #1;
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; clear = 1'b0;
      q_1 = '0; q_2 = '0; q_3 = '0;
      bus.evt_ready = 1'b1;
      repeat (2) tick();
      chk("rst_state", state, 0);
      chk("rst_mask", mask, 0);
      chk("rst_evt_valid", bus.evt_valid, 0);
      chk("rst_alarm", alarm, 0);

      // All replicas agree
      rst = 1'b0; q_1 = 64'd5; q_2 = 64'd5; q_3 = 64'd5; enable = 1'b1;
      #1;
      chk("agree_voted", voted_q, 5);
      chk("agree_cnt_en", cnt_enable, 1);
      chk("agree_state", state, 0);
      chk("agree_fc1", fault_cnt_1, 0);
      chk("agree_fc2", fault_cnt_2, 0);
      chk("agree_fc3", fault_cnt_3, 0);
      chk("agree_evt_valid", bus.evt_valid, 0);

      // Single replica-2 fault
      tick(); q_2 = 64'd9; #1;
      chk("mis_voted", voted_q, 5);
      chk("mis_cnt_en", cnt_enable, 0);
      tick(); q_2 = 64'd5; #1;
      chk("rs1_state", state, 1);
      chk("rs1_resync", resync, 1);
      chk("rs1_cnt_en", cnt_enable, 0);
      chk("rs1_fc2", fault_cnt_2, 1);
      chk("rs1_evt_valid", bus.evt_valid, 1);
      chk("rs1_evt_code", bus.evt_code, 4'b0110);
      tick();
      chk("rs2_state", state, 1);
      chk("rs2_resync", resync, 1);
      chk("rs2_evt_valid", bus.evt_valid, 0);
      tick();
      chk("rs_exit_state", state, 0);
      chk("rs_exit_resync", resync, 0);
      chk("rs_exit_cnt_en", cnt_enable, 1);

      // Two more replica-2 faults close together retire replica 2
      inject(2, 64'd9); tick(); tick();
      chk("f2_state", state, 0);
      inject(2, 64'd9); tick(); tick();
      chk("mask2_mask", mask, 3'b010);
      chk("mask2_state", state, 2);
      chk("mask2_evt_code", bus.evt_code, 4'b1010);
      chk("mask2_evt_valid", bus.evt_valid, 1);
      chk("mask2_fc2", fault_cnt_2, 3);
      chk("mask2_cnt_en", cnt_enable, 1);
      tick(); q_2 = 64'd123; #1;
      chk("deg_ignore_cnt_en", cnt_enable, 1);
      chk("deg_ignore_state", state, 2);
      tick(); q_1 = 64'd7; q_3 = 64'd8; #1;
      chk("deg_diff_voted", voted_q, 7);
      chk("deg_diff_cnt_en", cnt_enable, 0);
      tick();
      chk("deg_fail_state", state, 3);
      chk("deg_fail_alarm", alarm, 1);
      chk("deg_fail_voted", voted_q, 7);
      chk("deg_fail_code", bus.evt_code, 4'b1100);
      chk("deg_fail_resync", resync, 0);
      chk("deg_fail_cnt_en", cnt_enable, 0);

      // Clear returns to a clean NORMAL
      tick(); clear = 1'b1; q_1 = 64'd5; q_2 = 64'd5; q_3 = 64'd5; #1;
      tick(); clear = 1'b0; #1;
      chk("clr1_state", state, 0);
      chk("clr1_alarm", alarm, 0);
      chk("clr1_mask", mask, 0);
      chk("clr1_fc2", fault_cnt_2, 0);
      chk("clr1_evt_valid", bus.evt_valid, 0);
      chk("clr1_cnt_en", cnt_enable, 1);

      // Two replica-1 faults, a full clean window, then a third fault
      inject(1, 64'd3); tick(); tick();
      inject(1, 64'd3); tick(); tick();
      chk("cw_pre_state", state, 0);
      repeat (15) tick();
      inject(1, 64'd3); tick(); tick();
      chk("cw_state", state, 0);
      chk("cw_mask", mask, 0);
      chk("cw_fc1", fault_cnt_1, 3);
      // strike_1 is now 1: one more fault reaches 2, the next retires replica 1
      inject(1, 64'd3); tick(); tick();
      chk("cw_s2_mask", mask, 0);
      inject(1, 64'd3); tick(); tick();
      chk("cw_s3_state", state, 2);
      chk("cw_s3_mask", mask, 3'b001);
      chk("cw_s3_voted", voted_q, 5);

      // No majority at all
      tick(); clear = 1'b1; #1;
      tick(); clear = 1'b0; q_1 = 64'd1; q_2 = 64'd2; q_3 = 64'd4; #1;
      chk("nomaj_voted", voted_q, 0);
      chk("nomaj_state", state, 0);
      chk("nomaj_cnt_en", cnt_enable, 0);
      tick();
      chk("nomaj_fail_state", state, 3);
      chk("nomaj_fail_alarm", alarm, 1);
      chk("nomaj_fail_code", bus.evt_code, 4'b1100);
      chk("nomaj_fail_ovf", bus.evt_ovf, 0);
      // last_good held the bitwise-majority value 0 from the previous cycle
      q_1 = 64'd9; q_2 = 64'd9; q_3 = 64'd9; #1;
      chk("nomaj_fail_voted", voted_q, 0);
      tick(); clear = 1'b1; q_1 = 64'd5; q_2 = 64'd5; q_3 = 64'd5; #1;
      tick(); clear = 1'b0; #1;
      chk("clr2_state", state, 0);
      chk("clr2_alarm", alarm, 0);

      // Monitor stalled: second event is dropped
      bus.evt_ready = 1'b0;
      inject(2, 64'd9); tick(); tick();
      chk("ovf_first_valid", bus.evt_valid, 1);
      chk("ovf_first_code", bus.evt_code, 4'b0110);
      inject(3, 64'd9);
      chk("ovf_held_code", bus.evt_code, 4'b0110);
      chk("ovf_flag", bus.evt_ovf, 1);
      chk("ovf_state", state, 1);
      chk("ovf_fc3", fault_cnt_3, 1);

      // Asynchronous reset mid-RESYNC
      rst = 1'b1; #1;
      chk("arst_state", state, 0);
      chk("arst_resync", resync, 0);
      chk("arst_evt_valid", bus.evt_valid, 0);
      chk("arst_evt_ovf", bus.evt_ovf, 0);
      chk("arst_evt_code", bus.evt_code, 0);
      chk("arst_fc2", fault_cnt_2, 0);
      chk("arst_fc3", fault_cnt_3, 0);
      chk("arst_mask", mask, 0);
      chk("arst_alarm", alarm, 0);

      tick(); rst = 1'b0;
      tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
